// File: rtl/bcd_ctrl_pkg.sv
// Shared types and defaults for the BCD converter arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_ctrl_pkg;

  localparam int DIGITS    = 4;
  localparam int BIN_W_DEF = 12;
  localparam int BCD_W_DEF = DIGITS * 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit searching upward from last_grant+1.
// Latency: purely combinational.
// Backpressure: none; any_valid low means nothing to grant.
module rr_pick
  import bcd_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  grant,
  output logic             any_valid
);

  int              idx;
  logic [ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest pending requester wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx  = (int'(last_grant) + off) % N_REQ;
      cand = ID_W'(idx);
      if (req[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter among N_REQ requesters, round robin.
// Latency: conv_en one cycle after req seen in IDLE; done one cycle after conv_rdy.
// Backpressure: requesters hold req until done; later requests wait, no preemption.
module bcd_conv_arbiter
  import bcd_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BIN_W   = BIN_W_DEF,
  parameter int BCD_W   = BCD_W_DEF,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] req_bin,
  output logic [N_REQ-1:0]       done,
  output logic [BCD_W-1:0]       resp_bcd,
  output logic [ID_W-1:0]        resp_id,
  output logic                   err,
  output logic                   busy,
  output logic [BIN_W-1:0]       conv_bin,
  output logic                   conv_en,
  input  logic [BCD_W-1:0]       conv_bcd,
  input  logic                   conv_rdy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  id_q, last_grant, pick_id;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt;
  logic             rdy_hit, tmo_hit;

  logic [N_REQ-1:0] done_d;
  logic [BCD_W-1:0] resp_bcd_d;
  logic [ID_W-1:0]  resp_id_d;
  logic             err_d, busy_d, conv_en_d;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick_id),
    .any_valid  (pick_vld)
  );

  // conv_rdy only counts while waiting; the watchdog fires on the last WAIT cycle.
  assign rdy_hit = (state == ST_WAIT) && conv_rdy;
  assign tmo_hit = (state == ST_WAIT) && !conv_rdy && (cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pick_vld) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT:    if (rdy_hit || tmo_hit) state_nxt = ST_DELIVER;
      ST_DELIVER: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the response is decided on WAIT exit
  // so it appears in the DELIVER cycle, and is dropped if the requester gave up.
  always_comb begin
    done_d     = '0;
    resp_bcd_d = '0;
    resp_id_d  = '0;
    err_d      = 1'b0;
    conv_en_d  = (state == ST_IDLE) && pick_vld;
    busy_d     = (state_nxt != ST_IDLE);
    if ((rdy_hit || tmo_hit) && req[id_q]) begin
      done_d[id_q] = 1'b1;
      resp_id_d    = id_q;
      resp_bcd_d   = rdy_hit ? conv_bcd : '0;
      err_d        = tmo_hit;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= '0;
      resp_bcd <= '0;
      resp_id  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      conv_en  <= 1'b0;
    end else begin
      done     <= done_d;
      resp_bcd <= resp_bcd_d;
      resp_id  <= resp_id_d;
      err      <= err_d;
      busy     <= busy_d;
      conv_en  <= conv_en_d;
    end
  end

  // Grant capture, operand hold, round-robin pointer and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      conv_bin   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            id_q     <= pick_id;
            conv_bin <= req_bin[int'(pick_id)*BIN_W +: BIN_W];
          end
        end
        ST_ISSUE:   cnt <= '0;
        ST_WAIT:    if (!conv_rdy && !tmo_hit) cnt <= cnt + 1'b1;
        ST_DELIVER: last_grant <= id_q;
        default:    cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter; the bench plays the converter.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [47:0] req_bin;
  logic [3:0]  done;
  logic [15:0] resp_bcd;
  logic [1:0]  resp_id;
  logic        err, busy, conv_en, conv_rdy;
  logic [11:0] conv_bin;
  logic [15:0] conv_bcd;

  int tests  = 0;
  int failed = 0;
  int e;

  logic [11:0] ops     [4] = '{12'd1, 12'd22, 12'd333, 12'd4095};
  logic [15:0] exp_bcd [4] = '{16'h0001, 16'h0022, 16'h0333, 16'h4095};

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.N_REQ(4), .BIN_W(12), .BCD_W(16), .TIMEOUT(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_bin  (req_bin),
    .done     (done),
    .resp_bcd (resp_bcd),
    .resp_id  (resp_id),
    .err      (err),
    .busy     (busy),
    .conv_bin (conv_bin),
    .conv_en  (conv_en),
    .conv_bcd (conv_bcd),
    .conv_rdy (conv_rdy)
  );

  // Converter model: hand-computed BCD for the operands used here.
  function automatic logic [15:0] bcd_of(input logic [11:0] b);
    case (b)
      12'd1:    return 16'h0001;
      12'd22:   return 16'h0022;
      12'd255:  return 16'h0255;
      12'd333:  return 16'h0333;
      12'd4095: return 16'h4095;
      default:  return 16'hDEAD;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
    chk({tag, "_conv_en"},  32'(conv_en),  32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_resp_bcd"}, 32'(resp_bcd), 32'd0);
    chk({tag, "_resp_id"},  32'(resp_id),  32'd0);
    chk({tag, "_conv_bin"}, 32'(conv_bin), 32'd0);
  endtask

  // Caller has set req in an IDLE cycle; expects requester id to be granted and served.
  task automatic serve(input int id, input string tag);
    tick();
    chk({tag, "_conv_en"},  32'(conv_en),  32'd1);
    chk({tag, "_conv_bin"}, 32'(conv_bin), 32'(ops[id]));
    tick();
    conv_rdy = 1'b1;
    conv_bcd = bcd_of(conv_bin);
    tick();
    conv_rdy = 1'b0;
    chk({tag, "_done"},     32'(done),     32'(1 << id));
    chk({tag, "_resp_id"},  32'(resp_id),  32'(id));
    chk({tag, "_resp_bcd"}, 32'(resp_bcd), 32'(exp_bcd[id]));
    chk({tag, "_err"},      32'(err),      32'd0);
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_bin = '0; conv_rdy = 1'b0; conv_bcd = '0;
    tick(); tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single request, converter answers 30 cycles after conv_en.
    req_bin[11:0] = 12'd255;
    req = 4'b0001;
    tick();
    chk("t1_conv_en",  32'(conv_en),  32'd1);
    chk("t1_busy",     32'(busy),     32'd1);
    chk("t1_conv_bin", 32'(conv_bin), 32'd255);
    tick();
    chk("t1_en_pulse", 32'(conv_en),  32'd0);
    repeat (28) tick();
    chk("t1_no_early_done", 32'(done), 32'd0);
    conv_rdy = 1'b1;
    conv_bcd = bcd_of(conv_bin);
    tick();
    conv_rdy = 1'b0;
    chk("t1_done",     32'(done),     32'h1);
    chk("t1_resp_id",  32'(resp_id),  32'd0);
    chk("t1_resp_bcd", 32'(resp_bcd), 32'h0255);
    chk("t1_err",      32'(err),      32'd0);
    req = 4'b0000;
    tick();
    chk("t1_idle_done", 32'(done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // All four continuously requesting from a fresh reset: order 0,1,2,3,0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_bin[i*12 +: 12] = ops[i];
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      e = g % 4;
      chk("t2_conv_en",  32'(conv_en),  32'd1);
      chk("t2_conv_bin", 32'(conv_bin), 32'(ops[e]));
      tick(); tick(); tick();
      conv_rdy = 1'b1;
      conv_bcd = bcd_of(conv_bin);
      tick();
      conv_rdy = 1'b0;
      chk("t2_done",     32'(done),     32'(1 << e));
      chk("t2_resp_id",  32'(resp_id),  32'(e));
      chk("t2_resp_bcd", 32'(resp_bcd), 32'(exp_bcd[e]));
      chk("t2_err",      32'(err),      32'd0);
      if (g == 4) req = 4'b0000;
      tick();
      chk("t2_gap_en",   32'(conv_en),  32'd0);
      chk("t2_gap_busy", 32'(busy),     32'd0);
      tick();
    end
    chk("t2_stop_en", 32'(conv_en), 32'd0);

    // Converter never answers: done+err 65 cycles after conv_en, result 0.
    req = 4'b0010;
    tick();
    chk("t3_conv_en",  32'(conv_en),  32'd1);
    chk("t3_conv_bin", 32'(conv_bin), 32'd22);
    repeat (64) tick();
    chk("t3_not_yet_done", 32'(done), 32'd0);
    chk("t3_not_yet_err",  32'(err),  32'd0);
    chk("t3_busy",         32'(busy), 32'd1);
    tick();
    chk("t3_done",     32'(done),     32'h2);
    chk("t3_err",      32'(err),      32'd1);
    chk("t3_resp_bcd", 32'(resp_bcd), 32'd0);
    chk("t3_resp_id",  32'(resp_id),  32'd1);
    req = 4'b0000;
    tick();
    chk("t3_err_pulse", 32'(err), 32'd0);
    req = 4'b0001;
    serve(0, "t3_after");

    // Requester 2 drops mid-WAIT; 1 and 3 pending, 3 must win (last_grant=2).
    req = 4'b0100;
    tick();
    chk("t4_conv_bin", 32'(conv_bin), 32'd333);
    tick(); tick();
    req = 4'b1010;
    tick(); tick();
    conv_rdy = 1'b1;
    conv_bcd = bcd_of(conv_bin);
    tick();
    chk("t4_no_done", 32'(done), 32'd0);
    chk("t4_no_err",  32'(err),  32'd0);
    chk("t4_busy",    32'(busy), 32'd1);
    tick();
    conv_rdy = 1'b0;
    chk("t4_idle_done", 32'(done),    32'd0);
    chk("t4_idle_en",   32'(conv_en), 32'd0);
    tick();
    chk("t4_next_en",  32'(conv_en),  32'd1);
    chk("t4_next_bin", 32'(conv_bin), 32'd4095);
    tick();
    conv_rdy = 1'b1;
    conv_bcd = bcd_of(conv_bin);
    tick();
    chk("t4_done3",     32'(done),     32'h8);
    chk("t4_resp_id3",  32'(resp_id),  32'd3);
    chk("t4_resp_bcd3", 32'(resp_bcd), 32'h4095);

    // Stray conv_rdy in DELIVER and IDLE is ignored.
    conv_bcd = 16'h1234;
    req = 4'b0000;
    tick();
    chk("t6_idle_done", 32'(done), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_stray_done", 32'(done),    32'd0);
    chk("t6_stray_busy", 32'(busy),    32'd0);
    chk("t6_stray_en",   32'(conv_en), 32'd0);
    chk("t6_stray_err",  32'(err),     32'd0);
    conv_rdy = 1'b0;

    // Reset 10 cycles into WAIT; afterwards requester 0 wins first.
    req = 4'b0010;
    serve(1, "t5_pre");
    req = 4'b0100;
    tick();
    chk("t5_conv_en", 32'(conv_en), 32'd1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_zero("t5_async");
    tick();
    req = 4'b1111;
    rst_n = 1'b1;
    serve(0, "t5_post");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one 12-bit binary-to-BCD converter (shift/add-3 FSM, en/rdy handshake) among N requesters. It captures a requester's binary operand, launches the converter, waits for completion with a timeout watchdog, and returns the 16-bit packed BCD result tagged with the requester index. It sits between the display/readout clients and the single converter instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- BIN_W, 12, binary operand width
- BCD_W, 16, packed BCD result width (4 digits)
- TIMEOUT, 64, max cycles from conv_en to conv_rdy before abort
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level, held until its done pulse
- req_bin  in  N_REQ*BIN_W  operands; slice i = req_bin[i*BIN_W +: BIN_W], stable while req[i]=1
- done  out  N_REQ  one-cycle pulse to the serviced requester
- resp_bcd  out  BCD_W  result, valid only in the done cycle
- resp_id  out  clog2(N_REQ)  index of serviced requester, valid with done
- err  out  1  one-cycle pulse with done when the conversion timed out
- busy  out  1  high from ISSUE through DELIVER
- conv_bin  out  BIN_W  operand to converter
- conv_en  out  1  converter start, one-cycle pulse
- conv_bcd  in  BCD_W  converter result
- conv_rdy  in  1  converter completion pulse

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: if any req bit set, pick winner by round robin starting at last_grant+1 (mod N_REQ); latch id and operand into conv_bin; go ISSUE. Else stay.
- ISSUE: conv_en=1 for exactly this cycle; clear timeout counter; go WAIT.
- WAIT: conv_bin held constant. On conv_rdy: capture conv_bcd, go DELIVER. Else increment counter; at counter == TIMEOUT-1 without rdy: result forced to 0, set err flag, go DELIVER.
- DELIVER: if req[id] still 1: done[id]=1, resp_id=id, resp_bcd=captured, err=err flag. If req[id] dropped: no done, no err, result discarded. Update last_grant=id in both cases. Go IDLE.
- Requests arriving during ISSUE/WAIT/DELIVER wait; no preemption.
- conv_rdy outside WAIT is ignored.
- Reset (any time, incl. mid-conversion): state IDLE; done, err, conv_en, busy, resp_bcd, resp_id, conv_bin = 0; last_grant = N_REQ-1 so requester 0 wins first; timeout counter 0.

## Timing
- All outputs registered.
- req seen in IDLE at cycle t -> conv_en=1 and busy=1 at t+1; WAIT from t+2.
- conv_rdy sampled high at cycle r -> done/resp valid at r+1 (DELIVER) -> IDLE at r+2; earliest next conv_en at r+3, giving converter at least two idle cycles.
- Timeout: err/done asserted TIMEOUT+1 cycles after conv_en cycle.
- Requester holding req after done is re-arbitrated normally; with others pending it waits its round-robin turn.
- Counter width clog2(TIMEOUT+1); no wrap since WAIT exits at the limit.

## Structure
- Package bcd_ctrl_pkg: state enum, BIN_W/BCD_W defaults, DIGITS=4, id width helper.
- Sub-module rr_pick: combinational round-robin priority picker (req vector, last_grant -> grant index, any_valid); the arbiter instantiates it once.
- Converter instantiated outside this block; connected via conv_* ports.

## Test plan
- Single request: req=4'b0001, req_bin[0]=12'd255, model replies rdy with 16'h0255 after 30 cycles -> conv_en at t+1, done=4'b0001, resp_id=0, resp_bcd=16'h0255, err=0.
- All four requesting continuously, operands 1,22,333,4095 -> grant order 0,1,2,3,0; results 16'h0001,16'h0022,16'h0333,16'h4095.
- Converter never raises rdy, TIMEOUT=64 -> done and err pulse 65 cycles after conv_en, resp_bcd=0; next request serviced normally.
- Requester 2 drops req mid-WAIT -> no done, no err; last_grant=2, requester 3 served next.
- rst_n low 10 cycles into WAIT -> all outputs 0 immediately; after release with req=4'b1111, requester 0 granted first.
- Stray conv_rdy pulses in IDLE and DELIVER -> no done, no state change.
